// File: rtl/nbytes_spi_pkg.sv
// Shared types and sizing helpers for the n-byte frame SPI transmitter.
package nbytes_spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      SHIFT,
      CS_HOLD,
      GAP
   } state_t;

   localparam int BYTE_NUM_DEFAULT = 4;
   localparam int SCLK_DIV_DEFAULT = 4;
   localparam int CS_GAP_DEFAULT   = 2;

   function automatic int frame_width(input int byte_num);
      return 8 * byte_num;
   endfunction

   // Width of a 0..n-1 counter, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/nbytes_spi_tx_half_tick.sv
// SCLK half-period divider: one-cycle tick every DIV enabled cycles, restarting
// from zero whenever the enable rises.
module spi_half_tick
   import nbytes_spi_pkg::*;
#(
   parameter int DIV = SCLK_DIV_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int            CW   = cnt_width(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   assign tick_o = en_i && (cnt == LAST);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         cnt <= '0;
      else if (!en_i || tick_o)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/nbytes_spi_tx.sv
// Sends each parity-clean UART frame as one SPI mode-0 transaction (MSB first,
// CS low for the whole frame) and returns the full-duplex MISO word.
module nbytes_spi_tx
   import nbytes_spi_pkg::*;
#(
   parameter  int BYTE_NUM = BYTE_NUM_DEFAULT,
   parameter  int SCLK_DIV = SCLK_DIV_DEFAULT,
   parameter  int CS_GAP   = CS_GAP_DEFAULT,
   localparam int W        = frame_width(BYTE_NUM)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] frame_data_i,
   input  logic         frame_valid_i,
   input  logic         frame_crc_valid_i,
   output logic         spi_sclk_o,
   output logic         spi_cs_n_o,
   output logic         spi_mosi_o,
   input  logic         spi_miso_i,
   output logic [W-1:0] rx_data_o,
   output logic         rx_valid_o,
   output logic         busy_o,
   output logic         drop_o,
   output logic         overflow_o
);

   localparam int             BCW      = $clog2(W + 1);
   localparam int             GCW      = cnt_width(CS_GAP);
   localparam logic [BCW-1:0] BITS     = BCW'(W);
   localparam logic [GCW-1:0] GAP_LAST = GCW'(CS_GAP - 1);

   state_t         state;
   logic [W-1:0]   pend_data;
   logic           pend_full;
   logic [W-1:0]   tx_sr;
   logic [W-1:0]   rx_sr;
   logic [BCW-1:0] bit_cnt;
   logic [GCW-1:0] gap_cnt;
   logic           tick;
   logic           div_en;
   logic           drain;
   logic           frame_ok;
   logic           accept;

   assign div_en   = (state == CS_SETUP) || (state == SHIFT) || (state == CS_HOLD);
   assign drain    = (state == IDLE) && pend_full;
   assign frame_ok = frame_valid_i && frame_crc_valid_i;
   // A full buffer that is being drained this cycle can take the new frame.
   assign accept   = frame_ok && (!pend_full || drain);
   assign busy_o   = (state != IDLE) || pend_full;

   spi_half_tick #(.DIV(SCLK_DIV)) u_half_tick (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (div_en),
      .tick_o (tick)
   );

   // NOTE: pure data storage qualified by pend_full, so it carries no reset.
   always_ff @(posedge clk_i) begin
      if (accept)
         pend_data <= frame_data_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_full  <= 1'b0;
         drop_o     <= 1'b0;
         overflow_o <= 1'b0;
      end else begin
         drop_o     <= frame_valid_i && !frame_crc_valid_i;
         overflow_o <= frame_ok && !accept;
         if (accept)
            pend_full <= 1'b1;
         else if (drain)
            pend_full <= 1'b0;
      end
   end

   // NOTE: every register here uses <= so all branches see the pre-edge state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         spi_cs_n_o <= 1'b1;
         spi_sclk_o <= 1'b0;
         spi_mosi_o <= 1'b0;
         rx_data_o  <= '0;
         rx_valid_o <= 1'b0;
         tx_sr      <= '0;
         rx_sr      <= '0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
      end else begin
         rx_valid_o <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pend_full) begin
                  spi_cs_n_o <= 1'b0;
                  spi_mosi_o <= pend_data[W-1];
                  tx_sr      <= {pend_data[W-2:0], 1'b0};
                  bit_cnt    <= '0;
                  state      <= CS_SETUP;
               end
            end
            CS_SETUP: begin
               // The first rising edge ends the setup phase.
               if (tick) begin
                  spi_sclk_o <= 1'b1;
                  rx_sr      <= {rx_sr[W-2:0], spi_miso_i};
                  bit_cnt    <= BCW'(1);
                  state      <= SHIFT;
               end
            end
            SHIFT: begin
               if (tick) begin
                  if (spi_sclk_o) begin
                     spi_sclk_o <= 1'b0;
                     spi_mosi_o <= tx_sr[W-1];
                     tx_sr      <= {tx_sr[W-2:0], 1'b0};
                  end else if (bit_cnt == BITS) begin
                     state <= CS_HOLD;
                  end else begin
                     spi_sclk_o <= 1'b1;
                     rx_sr      <= {rx_sr[W-2:0], spi_miso_i};
                     bit_cnt    <= bit_cnt + 1'b1;
                  end
               end
            end
            CS_HOLD: begin
               if (tick) begin
                  spi_cs_n_o <= 1'b1;
                  spi_mosi_o <= 1'b0;
                  rx_data_o  <= rx_sr;
                  rx_valid_o <= 1'b1;
                  gap_cnt    <= '0;
                  state      <= GAP;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST)
                  state <= IDLE;
               else
                  gap_cnt <= gap_cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nbytes_spi_tx.sv
// Directed bench: a 4-byte/div-2 instance and a 1-byte/div-1 instance, with a
// bus monitor and scoreboard per instance.
module tb_nbytes_spi_tx;

   localparam int WA = 32;
   localparam int DA = 2;
   localparam int GA = 2;
   localparam int WB = 8;
   localparam int DB = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [WA-1:0] fd_a = '0;
   logic          fv_a = 1'b0, fc_a = 1'b0;
   logic          sclk_a, cs_a, mosi_a, miso_a, rxv_a, busy_a, drop_a, ovf_a;
   logic [WA-1:0] rxd_a;

   logic [WB-1:0] fd_b = '0;
   logic          fv_b = 1'b0, fc_b = 1'b0;
   logic          sclk_b, cs_b, mosi_b, rxv_b, busy_b, drop_b, ovf_b;
   logic [WB-1:0] rxd_b;

   logic          loop_a = 1'b1;
   logic          miso_drv = 1'b0;
   logic [31:0]   slave_word = '0;
   logic [31:0]   slave_sr = '0;
   assign miso_a = loop_a ? mosi_a : miso_drv;

   nbytes_spi_tx #(.BYTE_NUM(4), .SCLK_DIV(DA), .CS_GAP(GA)) dut_a (
      .clk_i(clk), .rst_i(rst), .frame_data_i(fd_a), .frame_valid_i(fv_a),
      .frame_crc_valid_i(fc_a), .spi_sclk_o(sclk_a), .spi_cs_n_o(cs_a),
      .spi_mosi_o(mosi_a), .spi_miso_i(miso_a), .rx_data_o(rxd_a),
      .rx_valid_o(rxv_a), .busy_o(busy_a), .drop_o(drop_a), .overflow_o(ovf_a)
   );

   nbytes_spi_tx #(.BYTE_NUM(1), .SCLK_DIV(DB), .CS_GAP(2)) dut_b (
      .clk_i(clk), .rst_i(rst), .frame_data_i(fd_b), .frame_valid_i(fv_b),
      .frame_crc_valid_i(fc_b), .spi_sclk_o(sclk_b), .spi_cs_n_o(cs_b),
      .spi_mosi_o(mosi_b), .spi_miso_i(mosi_b), .rx_data_o(rxd_b),
      .rx_valid_o(rxv_b), .busy_o(busy_b), .drop_o(drop_b), .overflow_o(ovf_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   logic [31:0] exp_tx_q[$], exp_rx_q[$];
   logic [7:0]  exp_b_q[$];

   // Monitor for instance A: CS length, CS gap, MOSI word on rising SCLK, MISO slave.
   logic        prev_cs_a = 1'b1, prev_sclk_a = 1'b0;
   int          low_a = 0, high_a = 0, bits_a = 0, rx_cnt_a = 0;
   bit          seen_txn_a = 1'b0;
   logic [31:0] mosi_word_a = '0;

   always @(negedge clk) begin
      if (rst) begin
         prev_cs_a = 1'b1; prev_sclk_a = 1'b0;
         low_a = 0; high_a = 0; bits_a = 0; seen_txn_a = 1'b0;
      end else begin
         if (!cs_a && prev_cs_a) begin
            if (seen_txn_a) check("cs_gap_a", 32'(high_a >= GA + 1), 1);
            low_a = 0; bits_a = 0; mosi_word_a = '0;
            slave_sr = slave_word;
            miso_drv = slave_sr[31];
            slave_sr = slave_sr << 1;
         end
         if (cs_a && !prev_cs_a) begin
            check("cs_low_len_a", low_a, (2 + 2 * WA) * DA);
            check("sclk_rises_a", bits_a, WA);
            check("rx_valid_at_cs_rise_a", rxv_a, 1);
            high_a = 0;
            seen_txn_a = 1'b1;
         end
         if (cs_a) high_a++; else low_a++;
         if (sclk_a && !prev_sclk_a) begin
            mosi_word_a = {mosi_word_a[30:0], mosi_a};
            bits_a++;
         end
         if (!sclk_a && prev_sclk_a) begin
            miso_drv = slave_sr[31];
            slave_sr = slave_sr << 1;
         end
         if (rxv_a) begin
            rx_cnt_a++;
            check("rx_queue_nonempty_a", 32'(exp_rx_q.size() > 0), 1);
            if (exp_rx_q.size() > 0) begin
               check("rx_data_a", rxd_a, exp_rx_q.pop_front());
               check("mosi_word_a", mosi_word_a, exp_tx_q.pop_front());
            end
         end
         prev_cs_a = cs_a; prev_sclk_a = sclk_a;
      end
   end

   // Monitor for instance B: CS length, SCLK period, read-back word.
   logic       prev_cs_b = 1'b1, prev_sclk_b = 1'b0;
   int         low_b = 0, cyc_b = 0, last_rise_b = -1, rx_cnt_b = 0;

   always @(negedge clk) begin
      cyc_b++;
      if (rst) begin
         prev_cs_b = 1'b1; prev_sclk_b = 1'b0; low_b = 0; last_rise_b = -1;
      end else begin
         if (!cs_b && prev_cs_b) begin
            low_b = 0; last_rise_b = -1;
         end
         if (cs_b && !prev_cs_b) begin
            check("cs_low_len_b", low_b, (2 + 2 * WB) * DB);
            check("rx_valid_at_cs_rise_b", rxv_b, 1);
         end
         if (!cs_b) low_b++;
         if (sclk_b && !prev_sclk_b) begin
            if (last_rise_b >= 0) check("sclk_period_b", cyc_b - last_rise_b, 2);
            last_rise_b = cyc_b;
         end
         if (rxv_b) begin
            rx_cnt_b++;
            check("rx_queue_nonempty_b", 32'(exp_b_q.size() > 0), 1);
            if (exp_b_q.size() > 0) check("rx_data_b", rxd_b, exp_b_q.pop_front());
         end
         prev_cs_b = cs_b; prev_sclk_b = sclk_b;
      end
   end

   task automatic send_a(input logic [31:0] d, input logic crc);
      fd_a = d; fv_a = 1'b1; fc_a = crc;
      @(negedge clk);
      fv_a = 1'b0; fc_a = 1'b0;
   endtask

   task automatic expect_a(input logic [31:0] tx, input logic [31:0] rx);
      exp_tx_q.push_back(tx);
      exp_rx_q.push_back(rx);
   endtask

   task automatic wait_rx_a(input int target, input int budget);
      int n = 0;
      while (rx_cnt_a < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("rx_count_a", rx_cnt_a, target);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, drops, cs_lows, busys, n;

      // Reset state.
      repeat (3) @(negedge clk);
      check("reset_ctrl_a", {cs_a, sclk_a, mosi_a, rxv_a, busy_a, drop_a, ovf_a}, 7'b1000000);
      check("reset_rxd_a", rxd_a, 0);
      check("reset_ctrl_b", {cs_b, sclk_b, mosi_b, rxv_b, busy_b}, 5'b10000);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 1: loopback frame, CS length and read-back checked by the monitor.
      expect_a(32'hA5C3_0F81, 32'hA5C3_0F81);
      send_a(32'hA5C3_0F81, 1'b1);
      check("busy_after_accept", busy_a, 1);
      wait_rx_a(1, 400);
      repeat (10) @(negedge clk);
      check("rx_data_holds", rxd_a, 32'hA5C3_0F81);
      check("idle_after_frame", busy_a, 0);

      // 2: parity-failed frame, then a lone crc pulse.
      send_a(32'h1234_5678, 1'b0);
      check("drop_pulse", drop_a, 1);
      check("busy_after_drop", busy_a, 0);
      fc_a = 1'b1;
      @(negedge clk);
      fc_a = 1'b0;
      drops = 0; cs_lows = 0; busys = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drops += int'(drop_a); cs_lows += int'(!cs_a); busys += int'(busy_a);
      end
      check("drop_single_pulse", drops, 0);
      check("cs_stays_high", cs_lows, 0);
      check("busy_stays_low", busys, 0);

      // 3: three frames ten cycles apart; the third overflows.
      base = rx_cnt_a;
      expect_a(32'h1111_1111, 32'h1111_1111);
      expect_a(32'h2222_2222, 32'h2222_2222);
      send_a(32'h1111_1111, 1'b1);
      repeat (9) @(negedge clk);
      send_a(32'h2222_2222, 1'b1);
      check("no_overflow_second", ovf_a, 0);
      repeat (9) @(negedge clk);
      send_a(32'h3333_3333, 1'b1);
      check("overflow_pulse", ovf_a, 1);
      check("no_drop_on_overflow", drop_a, 0);
      @(negedge clk);
      check("overflow_one_cycle", ovf_a, 0);
      wait_rx_a(base + 2, 800);
      repeat (20) @(negedge clk);
      check("third_not_sent", rx_cnt_a, base + 2);

      // 4: independent MISO pattern from the slave model.
      loop_a = 1'b0;
      slave_word = 32'hDEAD_BEEF;
      base = rx_cnt_a;
      expect_a(32'h0F0F_5AA5, 32'hDEAD_BEEF);
      send_a(32'h0F0F_5AA5, 1'b1);
      wait_rx_a(base + 1, 400);
      repeat (10) @(negedge clk);
      loop_a = 1'b1;

      // 5: reset in the middle of SHIFT, then a clean frame.
      base = rx_cnt_a;
      expect_a(32'hC0FF_EE42, 32'hC0FF_EE42);
      send_a(32'hC0FF_EE42, 1'b1);
      n = 0;
      while (bits_a != 17 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("reach_bit17", bits_a, 17);
      rst = 1'b1;
      #1;
      check("mid_reset_ctrl", {cs_a, sclk_a, mosi_a, busy_a, rxv_a}, 5'b10000);
      check("mid_reset_rxd", rxd_a, 0);
      exp_tx_q.delete();
      exp_rx_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("no_rx_after_abort", rx_cnt_a, base);
      check("idle_after_abort", cs_a, 1);
      expect_a(32'h5A5A_0FF0, 32'h5A5A_0FF0);
      send_a(32'h5A5A_0FF0, 1'b1);
      wait_rx_a(base + 1, 400);
      repeat (10) @(negedge clk);

      // 7: second frame arrives in the very cycle the first is drained.
      base = rx_cnt_a;
      expect_a(32'h7777_0001, 32'h7777_0001);
      expect_a(32'h7777_0002, 32'h7777_0002);
      fd_a = 32'h7777_0001; fv_a = 1'b1; fc_a = 1'b1;
      @(negedge clk);
      fd_a = 32'h7777_0002;
      @(negedge clk);
      fv_a = 1'b0; fc_a = 1'b0;
      check("no_overflow_on_drain", ovf_a, 0);
      wait_rx_a(base + 2, 800);
      repeat (10) @(negedge clk);

      // 6: single-byte instance at the fastest divider.
      exp_b_q.push_back(8'h3C);
      fd_b = 8'h3C; fv_b = 1'b1; fc_b = 1'b1;
      @(negedge clk);
      fv_b = 1'b0; fc_b = 1'b0;
      n = 0;
      while (rx_cnt_b < 1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (20) @(negedge clk);
      check("rx_valid_once_b", rx_cnt_b, 1);

      check("scoreboard_empty_a", exp_tx_q.size(), 0);
      check("scoreboard_empty_b", exp_b_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/nbytes_spi_tx.md
Name: nbytes_spi_tx

Overview:
Downstream consumer of the UART n-byte frame receiver. It takes each completed, parity-clean BYTE_NUM-byte frame and transmits it as one SPI mode-0 transaction (CS held low for the whole frame, MSB first). It captures MISO full-duplex and returns the read-back word. A one-deep pending buffer absorbs a frame that arrives while a transaction is in flight.

Parameters:
BYTE_NUM, 4, bytes per frame; frame width W = 8*BYTE_NUM; 1..8
SCLK_DIV, 4, clk_i cycles per SCLK half-period; >=1
CS_GAP, 2, clk_i cycles CS stays high between back-to-back frames; >=1

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-high reset
frame_data_i  in  W  frame from UART receiver; byte 0 received = bits [W-1:W-8]
frame_valid_i  in  1  1-cycle pulse: frame_data_i complete
frame_crc_valid_i  in  1  1-cycle pulse: all bytes passed parity; coincident with frame_valid_i
spi_sclk_o  out  1  SPI clock, idle low
spi_cs_n_o  out  1  chip select, active low
spi_mosi_o  out  1  serial data out
spi_miso_i  in  1  serial data in
rx_data_o  out  W  MISO word from last transaction; holds until next
rx_valid_o  out  1  1-cycle pulse: rx_data_o updated
busy_o  out  1  high when state != IDLE or pending buffer full
drop_o  out  1  1-cycle pulse: frame rejected (parity)
overflow_o  out  1  1-cycle pulse: frame rejected (buffer full)

Behaviour:
- Reset (async, any time, incl. mid-transaction): spi_cs_n_o=1, spi_sclk_o=0, spi_mosi_o=0, rx_data_o=0, rx_valid_o=0, busy_o=0, drop_o=0, overflow_o=0; pending buffer empty; state IDLE. No partial frame is resumed.
- Accept: frame_valid_i=1 and frame_crc_valid_i=1 -> frame written to pending buffer if it is empty or is being drained this same cycle.
- frame_valid_i=1, frame_crc_valid_i=0 -> frame discarded; drop_o pulses the next cycle.
- Valid frame arriving while pending is full and not draining -> discarded; overflow_o pulses the next cycle. Parity drop takes precedence: only drop_o fires.
- frame_crc_valid_i without frame_valid_i -> ignored.
- FSM states: IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP.
- IDLE: pending full -> move it to the TX shift register, clear pending, go to CS_SETUP. Next cycle: cs_n=0, mosi=bit W-1.
- CS_SETUP: lasts SCLK_DIV cycles with sclk=0, then SHIFT.
- SHIFT: sclk toggles every SCLK_DIV cycles.
  - Rising edge: sample miso into the RX shift register (MSB first).
  - Falling edge: present the next TX bit on mosi.
  - Exactly W rising edges. After the W-th rising edge, sclk falls SCLK_DIV cycles later, then go to CS_HOLD.
- CS_HOLD: SCLK_DIV cycles, sclk=0. Then cs_n=1, rx_data_o updated, and rx_valid_o pulsed in the same cycle; go to GAP. mosi=0 whenever cs_n=1.
- GAP: CS_GAP cycles, then IDLE.
- Timing: cs_n low for (2 + 2*W)*SCLK_DIV cycles. With IDLE, GAP adds CS_GAP+1 cycles, so min frame spacing = (2+2*W)*SCLK_DIV + CS_GAP + 1 cycles.
- Counters:
  - bit counter: clog2(W+1) bits.
  - divider counter: clog2(SCLK_DIV) bits, min 1; reloads on every state entry.
- Accept and IDLE->CS_SETUP in the same cycle is legal: the new frame lands in pending after the old frame is drained.

Decomposition:
- Package nbytes_spi_pkg: FSM state enum (3-bit), CS_GAP/SCLK_DIV defaults, function computing frame width and counter widths.
- Sub-module spi_half_tick: free-running divider, enabled in CS_SETUP/SHIFT/CS_HOLD. Emits a 1-cycle tick every SCLK_DIV cycles; restarts on enable rise.

Test Plan:
1. BYTE_NUM=4, SCLK_DIV=2; frame 32'hA5C3_0F81 with both valids; miso tied to mosi -> cs_n low 132 cycles; mosi bits on rising edges = A5C30F81 MSB first; rx_valid_o pulse with rx_data_o=32'hA5C3_0F81 at cs_n rise.
2. frame_valid_i=1, frame_crc_valid_i=0, data 32'h1234_5678 -> drop_o single pulse; cs_n stays 1; busy_o stays 0.
3. Three valid frames 32'h1111_1111, 32'h2222_2222, 32'h3333_3333 spaced 10 cycles apart -> first sent, second pending, third gives overflow_o; two transactions with CS high >=2 cycles between.
4. miso driven with 32'hDEAD_BEEF, sampled by bench on SCLK falling -> rx_data_o=32'hDEAD_BEEF; mosi unaffected.
5. Assert rst_i during SHIFT at bit 17 -> same cycle cs_n=1, sclk=0, mosi=0, busy_o=0, no rx_valid_o; next valid frame transmits fully and correctly.
6. SCLK_DIV=1, BYTE_NUM=1, frame 8'h3C -> cs_n low 18 cycles, sclk period 2 cycles, rx_valid_o exactly once.
